// File: rtl/knn_pkg.sv
// knn_pkg: shared widths, state encoding and saturating add for the k-NN distance/top-K stages
//   PIXEL_W/DIST_W/LABEL_W/NUM_PIXELS/IDX_W : default configuration
//   state_t                                 : distance-engine FSM states
//   sat_add(acc, sq, w)                     : acc+sq clamped to 2^w-1 (w <= 63)
package knn_pkg;

    localparam int PIXEL_W    = 8;
    localparam int DIST_W     = 32;
    localparam int LABEL_W    = 4;
    localparam int NUM_PIXELS = 64;
    localparam int IDX_W      = 16;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Computed one bit wider than the operands so the clamp test never sees a wrapped sum.
    function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] sq,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, sq};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/knn_sq_diff.sv
// knn_sq_diff: combinational squared absolute difference of two unsigned pixels
//   a, b : PIXEL_W unsigned inputs
//   sq   : (|a-b|)^2, 2*PIXEL_W unsigned (always fits, max (2^W-1)^2)
module knn_sq_diff #(
    parameter int PIXEL_W = 8
) (
    input  logic [PIXEL_W-1:0]   a,
    input  logic [PIXEL_W-1:0]   b,
    output logic [2*PIXEL_W-1:0] sq
);

    logic [PIXEL_W-1:0]   diff;
    logic [2*PIXEL_W-1:0] diff_w;

    assign diff   = (a > b) ? a - b : b - a;
    assign diff_w = {{PIXEL_W{1'b0}}, diff};
    assign sq     = diff_w * diff_w;

endmodule

// File: rtl/knn_distance_accum.sv
// knn_distance_accum: streaming squared-Euclidean distance between a query and one training image
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous abort; frame restarts at pixel 0, out_index returns to 0
//   in_valid/in_ready     : pixel-pair handshake (in_ready only in ACCUM)
//   in_query_px/train_px  : pixel pair at the same position
//   in_label              : training label, sampled on pixel 0
//   out_valid/out_ready   : result handshake (out_valid only in OUT)
//   out_distance          : saturating sum of squared differences
//   out_label/out_index   : label of the image and its ordinal since reset/clear
module knn_distance_accum #(
    parameter int NUM_PIXELS = knn_pkg::NUM_PIXELS,
    parameter int PIXEL_W    = knn_pkg::PIXEL_W,
    parameter int DIST_W     = knn_pkg::DIST_W,
    parameter int LABEL_W    = knn_pkg::LABEL_W,
    parameter int IDX_W      = knn_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_query_px,
    input  logic [PIXEL_W-1:0] in_train_px,
    input  logic [LABEL_W-1:0] in_label,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIST_W-1:0]  out_distance,
    output logic [LABEL_W-1:0] out_label,
    output logic [IDX_W-1:0]   out_index
);

    import knn_pkg::*;

    localparam int CNT_W = $clog2(NUM_PIXELS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PIXELS - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic [2*PIXEL_W-1:0] s1_sq;
    logic [2*PIXEL_W-1:0] sq;
    logic [DIST_W-1:0]    acc;
    logic [DIST_W-1:0]    acc_base;
    logic [DIST_W-1:0]    acc_next;
    logic [LABEL_W-1:0]   label_reg;
    logic                 hs;

    knn_sq_diff #(.PIXEL_W(PIXEL_W)) u_sq (
        .a  (in_query_px),
        .b  (in_train_px),
        .sq (sq)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign hs        = in_valid && in_ready;
    // The first flag restarts the sum, so the accumulator never needs an explicit clear.
    assign acc_base  = s1_first ? '0 : acc;
    assign acc_next  = DIST_W'(sat_add(64'(acc_base), 64'(s1_sq), DIST_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            count        <= '0;
            s1_valid     <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_sq        <= '0;
            acc          <= '0;
            label_reg    <= '0;
            out_distance <= '0;
            out_label    <= '0;
            out_index    <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            count     <= '0;
            s1_valid  <= 1'b0;
            out_index <= '0;
        end else begin
            s1_valid <= hs;
            if (hs) begin
                s1_sq    <= sq;
                s1_first <= (count == '0);
                s1_last  <= (count == LAST);
                count    <= (count == LAST) ? '0 : count + 1'b1;
                if (count == '0)
                    label_reg <= in_label;
            end
            if (s1_valid)
                acc <= acc_next;
            // The last accumulate lands on the DRAIN edge; publish the result in the same cycle.
            if (s1_valid && s1_last) begin
                out_distance <= acc_next;
                out_label    <= label_reg;
            end
            case (state)
                ACCUM: state <= (hs && count == LAST) ? DRAIN : ACCUM;
                DRAIN: state <= OUT;
                OUT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_index <= out_index + 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
